// File: rtl/hcsr04_echo_capture.sv
// ---------------------------------------------------------------------------
// hcsr04_echo_capture
//
// Drives the HC-SR04 ultrasonic sensor mounted over the fuel tank and
// measures the echo pulse width in clk cycles. A trigger pulse is issued
// once per measurement period. The asynchronous echo pin is synchronised,
// and the echo-high time is counted. Each measurement ends in exactly one
// strobe: data_valid (distance_raw updated) or timeout (distance_raw held).
// At 50 MHz one cm of range is roughly 2900 counts.
//
// Handshake: data_valid and timeout are single-cycle strobes with no
// back-pressure. The downstream stage must capture distance_raw in the
// cycle data_valid is high. distance_raw stays stable until the next
// data_valid.
//
// Ports
//   clk           in   system clock (50 MHz nominal)
//   rst_n         in   synchronous reset, active low
//   enable        in   1 = run periodic measurements; 0 = stop after the current one
//   echo          in   sensor echo pin, asynchronous
//   trig          out  sensor trigger pin
//   distance_raw  out  last valid echo width in clk cycles
//   data_valid    out  1-cycle strobe: distance_raw updated this cycle
//   timeout       out  1-cycle strobe: measurement aborted, distance_raw unchanged
//   busy          out  1 whenever the FSM is not IDLE
//   state_dbg     out  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module hcsr04_echo_capture #(
  parameter int RAW_W          = 21,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_900_000,
  parameter int PERIOD_CYCLES  = 3_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic [RAW_W-1:0] distance_raw,
  output logic             data_valid,
  output logic             timeout,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);

  localparam logic [TW-1:0]    TRIG_LAST  = TW'(TRIG_CYCLES - 1);
  localparam logic [RAW_W-1:0] TIMEOUT_V  = RAW_W'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0]    PERIOD_V   = PW'(PERIOD_CYCLES);
  localparam logic [PW-1:0]    PERIOD_M1  = PW'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  state_e           state_q;
  logic             echo_meta_q;
  logic             echo_s_q;
  logic             echo_d_q;
  logic [TW-1:0]    trig_cnt_q;
  logic [PW-1:0]    period_q;
  logic [RAW_W-1:0] meas_cnt_q;
  logic [RAW_W-1:0] distance_q;
  logic             trig_q;
  logic             data_valid_q;
  logic             timeout_q;
  logic             busy_q;

  logic             echo_rise;
  logic             echo_fall;
  logic [RAW_W-1:0] meas_inc;

  assign echo_rise = echo_s_q & ~echo_d_q;
  assign echo_fall = ~echo_s_q & echo_d_q;
  // One counter serves both as the rise-wait counter and the echo-width
  // counter; the two phases never overlap.
  assign meas_inc  = meas_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      echo_meta_q  <= 1'b0;
      echo_s_q     <= 1'b0;
      echo_d_q     <= 1'b0;
      trig_cnt_q   <= '0;
      period_q     <= '0;
      meas_cnt_q   <= '0;
      distance_q   <= '0;
      trig_q       <= 1'b0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      echo_meta_q  <= echo;
      echo_s_q     <= echo_meta_q;
      echo_d_q     <= echo_s_q;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;

      if (period_q != PERIOD_V) begin
        period_q <= period_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= TRIG;
            trig_q     <= 1'b1;
            busy_q     <= 1'b1;
            trig_cnt_q <= '0;
            period_q   <= '0;
          end
        end

        TRIG: begin
          if (trig_cnt_q == TRIG_LAST) begin
            state_q    <= WAIT_RISE;
            trig_q     <= 1'b0;
            meas_cnt_q <= '0;
          end else begin
            trig_cnt_q <= trig_cnt_q + 1'b1;
          end
        end

        WAIT_RISE: begin
          if (echo_rise) begin
            // The cycle in which the rise is seen already counts as one
            // echo-high cycle.
            meas_cnt_q <= RAW_W'(1);
            state_q    <= MEASURE;
          end else begin
            meas_cnt_q <= meas_inc;
            if (meas_inc == TIMEOUT_V) begin
              timeout_q <= 1'b1;
              state_q   <= HOLDOFF;
            end
          end
        end

        MEASURE: begin
          if (echo_fall) begin
            distance_q   <= meas_cnt_q;
            data_valid_q <= 1'b1;
            state_q      <= HOLDOFF;
          end else if (echo_s_q) begin
            meas_cnt_q <= meas_inc;
            if (meas_inc == TIMEOUT_V) begin
              timeout_q <= 1'b1;
              state_q   <= HOLDOFF;
            end
          end
        end

        HOLDOFF: begin
          // period_q is zero in the first trigger cycle, so it reads
          // PERIOD_CYCLES-1 in the last cycle of the period. Leaving here
          // then puts the next trig rise exactly PERIOD_CYCLES after the
          // previous one. An overrun leaves period_q saturated, so the
          // exit happens on the first HOLDOFF cycle.
          if (period_q >= PERIOD_M1) begin
            if (enable) begin
              state_q    <= TRIG;
              trig_q     <= 1'b1;
              trig_cnt_q <= '0;
              period_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig         = trig_q;
  assign distance_raw = distance_q;
  assign data_valid   = data_valid_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hcsr04_echo_capture.sv
// ---------------------------------------------------------------------------
// tb_hcsr04_echo_capture
//
// Instance dut_a uses a 300-cycle period. It runs a directed table of
// echo patterns, then randomized echo pulses, then a mid-measure reset.
// Instance dut_b uses a 50-cycle period and checks the period-overrun case.
// Expected outcomes come from a cycle-arithmetic reference model. The model
// is expressed relative to the trig falling edge.
// ---------------------------------------------------------------------------
module tb_hcsr04_echo_capture;

  localparam int RAW_W = 21;
  localparam int TRIG  = 5;
  localparam int TO    = 100;
  localparam int PER   = 300;
  localparam int PER_B = 50;

  localparam int K_VALID   = 1;
  localparam int K_TIMEOUT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             enable_a, echo_a, trig_a, dv_a, to_a, busy_a;
  logic [RAW_W-1:0] dist_a;
  logic [2:0]       st_a;
  logic             enable_b, echo_b, trig_b, dv_b, to_b, busy_b;
  logic [RAW_W-1:0] dist_b;
  logic [2:0]       st_b;

  hcsr04_echo_capture #(.RAW_W(RAW_W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO),
                        .PERIOD_CYCLES(PER)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .echo(echo_a), .trig(trig_a),
    .distance_raw(dist_a), .data_valid(dv_a), .timeout(to_a), .busy(busy_a),
    .state_dbg(st_a));

  hcsr04_echo_capture #(.RAW_W(RAW_W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO),
                        .PERIOD_CYCLES(PER_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .echo(echo_b), .trig(trig_b),
    .distance_raw(dist_b), .data_valid(dv_b), .timeout(to_b), .busy(busy_b),
    .state_dbg(st_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [RAW_W-1:0] exp_q[$];
  int               rise_q[$];
  int               fall_q[$];
  int               dv_cyc_q[$];
  logic [RAW_W-1:0] dv_val_q[$];
  int               to_cyc_q[$];
  int               both_cnt   = 0;
  logic             trig_prev  = 1'b0;
  int               exp_next_rise = -1;
  int               last_valid    = 0;

  // Event monitor for dut_a, sampled on the falling edge.
  always @(negedge clk) begin
    if (trig_a && !trig_prev) rise_q.push_back(cyc);
    if (!trig_a && trig_prev) fall_q.push_back(cyc);
    trig_prev = trig_a;
    if (dv_a) begin
      dv_cyc_q.push_back(cyc);
      dv_val_q.push_back(dist_a);
    end
    if (to_a) to_cyc_q.push_back(cyc);
    if (dv_a && to_a) both_cnt++;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model. The echo pin is first sampled high delay+1 cycles
  // after trig falls and stays high for width cycles. width=0 or stuck
  // means no rising edge is seen. The returned ev_off is the strobe cycle,
  // counted from the trig fall.
  function automatic void model(input int delay, input int width, input bit stuck,
                                output int kind, output int ev_off, output int val);
    val = 0;
    if (stuck || width == 0 || delay + 3 > TO) begin
      kind   = K_TIMEOUT;
      ev_off = TO;
    end else if (width < TO) begin
      kind   = K_VALID;
      ev_off = delay + 1 + width + 2;
      val    = width;
    end else begin
      kind   = K_TIMEOUT;
      ev_off = delay + 1 + TO + 1;
    end
  endfunction

  // Runs one dut_a measurement and scores it against the model.
  // exp_kind and exp_val are the independently stated expected outcome.
  task automatic run_meas(input string name, input int delay, input int width,
                          input bit stuck, input bit drop_en,
                          input int exp_kind, input int exp_val);
    int r, f, guard, kind, ev_off, val, ev, got_kind, got_cyc, got_val;
    if (stuck) echo_a = 1'b1;
    guard = 0;
    while (rise_q.size() == 0 && guard < 1000) begin tick; guard++; end
    if (rise_q.size() == 0) begin check({name, "/trig_rise_seen"}, 0, 1); return; end
    r = rise_q.pop_front();
    if (exp_next_rise >= 0) check({name, "/rise_cycle"}, r, exp_next_rise);
    if (drop_en) enable_a = 1'b0;
    guard = 0;
    while (fall_q.size() == 0 && guard < 50) begin tick; guard++; end
    if (fall_q.size() == 0) begin check({name, "/trig_fall_seen"}, 0, 1); return; end
    f = fall_q.pop_front();
    check({name, "/trig_width"}, f - r, TRIG);

    model(delay, width, stuck, kind, ev_off, val);
    check({name, "/model_kind"}, kind, exp_kind);
    if (kind == K_VALID) exp_q.push_back(RAW_W'(exp_val));
    ev = f + ev_off;

    if (!stuck && width > 0) begin
      while (cyc < f + delay) tick;
      echo_a = 1'b1;
      repeat (width) tick;
      echo_a = 1'b0;
    end

    guard = 0;
    while (dv_cyc_q.size() + to_cyc_q.size() == 0 && guard < 300) begin tick; guard++; end
    got_kind = 0; got_cyc = -1; got_val = -1;
    if (dv_cyc_q.size() > 0) begin
      got_kind = K_VALID;
      got_cyc  = dv_cyc_q.pop_front();
      got_val  = int'(dv_val_q.pop_front());
    end else if (to_cyc_q.size() > 0) begin
      got_kind = K_TIMEOUT;
      got_cyc  = to_cyc_q.pop_front();
    end
    check({name, "/strobe_kind"}, got_kind, exp_kind);
    check({name, "/strobe_cycle"}, got_cyc, ev);
    if (exp_kind == K_VALID && exp_q.size() > 0) begin
      check({name, "/distance"}, got_val, int'(exp_q.pop_front()));
      last_valid = exp_val;
    end else begin
      check({name, "/distance_held"}, int'(dist_a), last_valid);
    end
    if (stuck) echo_a = 1'b0;
    repeat (4) tick;
    check({name, "/extra_strobes"}, dv_cyc_q.size() + to_cyc_q.size(), 0);
    exp_next_rise = drop_en ? -1 : ((r + PER > ev + 1) ? r + PER : ev + 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string name;
    int    delay;
    int    width;
    bit    stuck;
    bit    drop_en;
    int    exp_kind;
    int    exp_val;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int k, r, f, e, h, guard, kind, ev_off, val, d, w;

    tbl[0] = '{"echo40",        20,  40, 1'b0, 1'b0, K_VALID,   40};
    tbl[1] = '{"no_echo",        0,   0, 1'b0, 1'b0, K_TIMEOUT,  0};
    tbl[2] = '{"echo150",       10, 150, 1'b0, 1'b0, K_TIMEOUT,  0};
    tbl[3] = '{"stuck_high",     0,   0, 1'b1, 1'b0, K_TIMEOUT,  0};
    tbl[4] = '{"width1",         0,   1, 1'b0, 1'b0, K_VALID,    1};
    tbl[5] = '{"width99",        0,  99, 1'b0, 1'b0, K_VALID,   99};
    tbl[6] = '{"width100",       0, 100, 1'b0, 1'b0, K_TIMEOUT,  0};
    tbl[7] = '{"late_rise_ok",  97,  10, 1'b0, 1'b0, K_VALID,   10};
    tbl[8] = '{"late_rise_to",  98,  10, 1'b0, 1'b0, K_TIMEOUT,  0};
    tbl[9] = '{"drop_enable",   30,  20, 1'b0, 1'b1, K_VALID,   20};

    rst_n = 1'b0; enable_a = 1'b0; echo_a = 1'b0; enable_b = 1'b0; echo_b = 1'b0;
    repeat (3) tick;
    check("reset/trig", trig_a, 0);
    check("reset/busy", busy_a, 0);
    check("reset/distance", int'(dist_a), 0);
    check("reset/strobes", dv_a + to_a, 0);
    check("reset/state", st_a, 0);
    rst_n = 1'b1;
    tick;
    check("idle/busy", busy_a, 0);

    // enable in IDLE: trig rises one cycle after the sampling edge
    enable_a = 1'b1;
    k = cyc;
    tick;
    check("start/trig", trig_a, 1);
    check("start/rise_cycle", (rise_q.size() > 0) ? rise_q[0] : -1, k + 1);

    for (int i = 0; i < 10; i++)
      run_meas(tbl[i].name, tbl[i].delay, tbl[i].width, tbl[i].stuck, tbl[i].drop_en,
               tbl[i].exp_kind, tbl[i].exp_val);

    // After the enable drop, the FSM must settle in IDLE with no further trigger.
    while (cyc < PER + 10 + ((rise_q.size() > 0) ? rise_q[0] : 0) && busy_a) tick;
    repeat (PER) tick;
    check("disabled/busy", busy_a, 0);
    check("disabled/no_rise", rise_q.size(), 0);
    enable_a = 1'b1;
    k = cyc;
    tick;
    check("reenable/rise_cycle", (rise_q.size() > 0) ? rise_q[0] : -1, k + 1);

    // Randomized echo pulses scored by the model.
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 105));
      w = int'($urandom_range(1, 140));
      model(d, w, 1'b0, kind, ev_off, val);
      run_meas($sformatf("rand%0d", i), d, w, 1'b0, 1'b0, kind, val);
    end

    // Reset for one cycle in the middle of MEASURE.
    guard = 0;
    while (rise_q.size() == 0 && guard < 1000) begin tick; guard++; end
    void'(rise_q.pop_front());
    guard = 0;
    while (fall_q.size() == 0 && guard < 50) begin tick; guard++; end
    f = (fall_q.size() > 0) ? fall_q.pop_front() : cyc;
    while (cyc < f + 10) tick;
    echo_a = 1'b1;
    repeat (20) tick;
    rst_n = 1'b0;
    tick;
    rst_n  = 1'b1;
    echo_a = 1'b0;
    check("midreset/trig", trig_a, 0);
    check("midreset/busy", busy_a, 0);
    check("midreset/distance", int'(dist_a), 0);
    check("midreset/strobes", dv_cyc_q.size() + to_cyc_q.size() + dv_a + to_a, 0);
    k = cyc;
    tick;
    check("midreset/restart_trig", trig_a, 1);
    check("midreset/restart_cycle", (rise_q.size() > 0) ? rise_q[0] : -1, k + 1);
    exp_next_rise = -1;
    last_valid    = 0;
    run_meas("after_reset", 20, 40, 1'b0, 1'b0, K_VALID, 40);
    enable_a = 1'b0;

    // Overrun: a 50-cycle period with an 80-cycle echo.
    k = cyc;
    enable_b = 1'b1;
    guard = 0;
    while (!trig_b && guard < 10) begin tick; guard++; end
    r = cyc;
    check("overrun/rise_cycle", r, k + 1);
    guard = 0;
    while (trig_b && guard < 20) begin tick; guard++; end
    check("overrun/trig_width", cyc - r, TRIG);
    f = cyc;
    while (cyc < f + 20) tick;
    echo_b = 1'b1;
    repeat (80) tick;
    echo_b = 1'b0;
    e = cyc;
    guard = 0;
    while (!dv_b && guard < 10) begin tick; guard++; end
    check("overrun/dv_latency", cyc - e, 3);
    check("overrun/distance", int'(dist_b), 80);
    h = cyc;
    guard = 0;
    while (!trig_b && guard < 10) begin tick; guard++; end
    check("overrun/next_rise", cyc - h, 1);
    enable_b = 1'b0;

    check("never_both_strobes", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
